// File: rtl/seg_dac_encoder.sv
// Registered segmented DAC code encoder: unary thermometer MSBs plus binary LSBs.
// Define SEG_DAC_DWA_EN to enable data-weighted-averaging rotation of the unary elements.
module seg_dac_encoder #(
   parameter int unsigned  CODE_W = 8,
   parameter int unsigned  MSB_W  = 3,
   localparam int unsigned LSB_W  = CODE_W - MSB_W,
   localparam int unsigned T      = (1 << MSB_W) - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] code_in,
   input  logic              ptr_clr,
   output logic              out_valid,
   output logic [T-1:0]      therm_out,
   output logic [LSB_W-1:0]  lsb_out,
   output logic [MSB_W-1:0]  ptr_out
);

   logic [MSB_W-1:0] k;
   logic [MSB_W-1:0] base;
   logic [MSB_W-1:0] ptr_q;
   logic [T-1:0]     mask;
   logic [T-1:0]     therm_nxt;
   logic [2*T-1:0]   dbl;

   assign k = code_in[CODE_W-1:LSB_W];

   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(T); i++) begin
         mask[i] = (MSB_W'(i) < k);
      end
      // Rotate left by base within T bits: both copies shifted, upper half is the wrap.
      dbl       = {mask, mask} << base;
      therm_nxt = dbl[2*T-1:T];
   end

`ifdef SEG_DAC_DWA_EN
   logic [MSB_W:0]   sum;
   logic [MSB_W:0]   sum_wrap;
   logic [MSB_W-1:0] ptr_nxt;

   always_comb begin
      base     = ptr_clr ? '0 : ptr_q;
      sum      = {1'b0, base} + {1'b0, k};
      sum_wrap = (sum >= (MSB_W+1)'(T)) ? sum - (MSB_W+1)'(T) : sum;
      ptr_nxt  = sum_wrap[MSB_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (in_valid) begin
         ptr_q <= ptr_nxt;
      end else if (ptr_clr) begin
         ptr_q <= '0;
      end
   end
`else
   logic unused_ptr_clr;

   assign unused_ptr_clr = ptr_clr;
   assign base           = '0;
   assign ptr_q          = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         therm_out <= '0;
         lsb_out   <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            therm_out <= therm_nxt;
            lsb_out   <= code_in[LSB_W-1:0];
         end
      end
   end

   assign ptr_out = ptr_q;

endmodule

// File: tb/tb_seg_dac_encoder.sv
// Randomized self-checking bench for seg_dac_encoder against a behavioural DWA model.
// Follows SEG_DAC_DWA_EN the same way as the design build.
module tb_seg_dac_encoder;

   localparam int unsigned CODE_W = 8;
   localparam int unsigned MSB_W  = 3;
   localparam int unsigned LSB_W  = CODE_W - MSB_W;
   localparam int unsigned T      = (1 << MSB_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [CODE_W-1:0] code_in = '0;
   logic              ptr_clr = 1'b0;
   logic              out_valid;
   logic [T-1:0]      therm_out;
   logic [LSB_W-1:0]  lsb_out;
   logic [MSB_W-1:0]  ptr_out;

   seg_dac_encoder #(.CODE_W(CODE_W), .MSB_W(MSB_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .code_in   (code_in),
      .ptr_clr   (ptr_clr),
      .out_valid (out_valid),
      .therm_out (therm_out),
      .lsb_out   (lsb_out),
      .ptr_out   (ptr_out)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Reference state: pointer, held outputs, per-element usage.
   int unsigned m_p     = 0;
   int unsigned m_therm = 0;
   int unsigned m_lsb   = 0;
   int unsigned m_valid = 0;
   int unsigned m_k     = 0;
   int unsigned usage[T];
   bit          count_usage = 1'b0;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".therm"}, 32'(therm_out), m_therm);
      check({tag, ".lsb"},   32'(lsb_out),   m_lsb);
      check({tag, ".ptr"},   32'(ptr_out),   m_p);
      check({tag, ".valid"}, 32'(out_valid), m_valid);
   endtask

   task automatic model_step(input bit v, input int unsigned code, input bit clr);
      int unsigned b;
      int unsigned e;
      if (v) begin
         m_k = code >> LSB_W;
         b   = clr ? 0 : m_p;
`ifndef SEG_DAC_DWA_EN
         b = 0;
`endif
         e = 0;
         for (int j = 0; j < int'(m_k); j++) e |= 1 << ((b + j) % T);
         m_therm = e;
         m_lsb   = code % (1 << LSB_W);
         m_p     = (b + m_k) % T;
         m_valid = 1;
      end else begin
         if (clr) m_p = 0;
         m_valid = 0;
      end
`ifndef SEG_DAC_DWA_EN
      m_p = 0;
`endif
   endtask

   // Drive at the falling edge, check 1 time unit after the rising edge.
   task automatic apply(input string tag, input bit v, input int unsigned code, input bit clr);
      @(negedge clk);
      in_valid = v;
      code_in  = CODE_W'(code);
      ptr_clr  = clr;
      @(posedge clk);
      #1;
      model_step(v, code, clr);
      check_all(tag);
      if (v) check({tag, ".popcount"}, 32'($countones(therm_out)), m_k);
      if (count_usage && out_valid)
         for (int i = 0; i < int'(T); i++) usage[i] += 32'(therm_out[i]);
   endtask

   task automatic check_usage(input string tag);
      int unsigned mn;
      int unsigned mx;
      mn = usage[0];
      mx = usage[0];
      for (int i = 1; i < int'(T); i++) begin
         if (usage[i] < mn) mn = usage[i];
         if (usage[i] > mx) mx = usage[i];
      end
      check(tag, ((mx - mn) <= 1) ? 1 : 0, 1);
   endtask

   task automatic reset_model();
      m_p = 0; m_therm = 0; m_lsb = 0; m_valid = 0;
   endtask

   initial begin
      reset_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Load nonzero state, then assert reset between edges with a sample in flight.
      apply("pre", 1, 8'hE3, 0);
      @(negedge clk);
      in_valid = 1'b1;
      code_in  = 8'hFF;
      #2 rst = 1'b1;
      #1;
      reset_model();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;

      apply("first", 1, 8'h65, 0);       // k=3 b=5
      apply("wrap", 1, 5 << LSB_W, 0);   // k=5 from p=3
      apply("kmax", 1, 8'hFF, 0);        // k=7
      apply("kzero", 1, 8'h1A, 0);       // k=0
      apply("to5", 1, 4 << LSB_W, 0);
      apply("clr_v", 1, (4 << LSB_W) | 9, 1);
      apply("gap", 0, 8'hFF, 0);
      apply("clr_idle", 0, 8'h00, 1);
      apply("after_clr", 1, (3 << LSB_W) | 2, 0);
      apply("b2b_a", 1, (6 << LSB_W) | 31, 0);
      apply("b2b_b", 1, (2 << LSB_W) | 1, 0);

      // Fresh start so element usage is balanced from zero.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      reset_model();
      for (int i = 0; i < int'(T); i++) usage[i] = 0;
      count_usage = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         apply("rand", ($urandom_range(0, 99) < 85), $urandom_range(0, 255), 0);
`ifdef SEG_DAC_DWA_EN
         if (n % 1000 == 999) check_usage("usage_balance");
`endif
      end
      count_usage = 1'b0;

      for (int n = 0; n < 500; n++)
         apply("rand_clr", ($urandom_range(0, 99) < 80), $urandom_range(0, 255),
               ($urandom_range(0, 99) < 15));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
